sha1_core_unrolled: RTL and testbench

Parametrised SHA-1 compression engine, the next-generation replacement for the single-round SHA-1 core in the crypto subsystem. It accepts 512-bit message blocks as 16 big-endian 32-bit words over a valid/ready handshake. It executes `RPC` rounds per clock, supports chaining from the previous digest for multi-block messages, and holds the 160-bit digest under a valid/ready output handshake. Padding and length encoding are done upstream.

---
 rtl/sha1_core_unrolled.sv | 234 +++++++++++++++++++++++
 tb/tb_sha1_core_unrolled.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_core_unrolled.sv
// -----------------------------------------------------------------------------
// sha1_core_unrolled
//
// SHA-1 compression engine that executes RPC rounds per clock. A 512-bit
// message block arrives as 16 big-endian 32-bit words over a valid/ready
// handshake. The resulting 160-bit digest is held under a valid/ready output
// handshake. Multi-block messages chain from the stored digest. Padding and
// length encoding happen upstream.
//
// Parameters
//   RPC       rounds per clock; legal values are 1, 2, 4 and 5
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous, active-high reset
//   din_vld   message word valid
//   din_rdy   engine can accept a message word this cycle
//   din       message word W[t], word 0 first
//   chain     sampled with word 0: 1 = start from stored digest, 0 = IV
//   busy      high from the word-0 accept until the digest is registered
//   dout      digest {h0,h1,h2,h3,h4}; also the stored chaining digest
//   dout_vld  digest valid, held until consumed
//   dout_rdy  consumer takes the digest on an edge with dout_vld high
// -----------------------------------------------------------------------------
module sha1_core_unrolled #(
   parameter int RPC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         din_vld,
   output logic         din_rdy,
   input  logic [31:0]  din,
   input  logic         chain,
   output logic         busy,
   output logic [159:0] dout,
   output logic         dout_vld,
   input  logic         dout_rdy
);

   // RPC must divide 20 so that one cycle never spans two round stages.
   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5)) begin : g_rpc_check
      $error("sha1_core_unrolled: RPC must be 1, 2, 4 or 5");
   end

   localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                  32'h10325476, 32'hC3D2E1F0};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMP,
      FIN
   } state_t;

   state_t        state;
   state_t        state_next;

   logic [3:0]    word_cnt;
   logic [6:0]    round_cnt;
   logic [31:0]   a, b, c, d, e;
   logic [159:0]  cv;
   logic [31:0]   w [16];

   logic [31:0]   a_nx, b_nx, c_nx, d_nx, e_nx;
   logic [31:0]   w_nx [16];

   logic          accept;
   logic          last_round;
   logic [159:0]  start_value;

   // Round-stage boolean function selected by the absolute round index.
   function automatic logic [31:0] f_func(input logic [6:0]  r,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] z);
      if (r < 7'd20)
         return (x & y) | (~x & z);
      else if (r >= 7'd40 && r < 7'd60)
         return (x & y) | (x & z) | (y & z);
      else
         return x ^ y ^ z;
   endfunction

   // Round-stage additive constant selected by the absolute round index.
   function automatic logic [31:0] k_func(input logic [6:0] r);
      if (r < 7'd20)
         return 32'h5A827999;
      else if (r < 7'd40)
         return 32'h6ED9EBA1;
      else if (r < 7'd60)
         return 32'h8F1BBCDC;
      else
         return 32'hCA62C1D6;
   endfunction

   // Input is blocked outside IDLE/LOAD, and also whenever a digest is still
   // waiting for its consumer, so FIN can never overwrite an unread digest.
   // A digest consumed on this very edge does not block a new word.
   assign din_rdy     = ((state == IDLE) || (state == LOAD)) && !(dout_vld && !dout_rdy);
   assign accept      = din_vld && din_rdy;
   assign last_round  = (round_cnt == 7'(80 - RPC));
   assign start_value = chain ? dout : IV;

   // The unrolled round datapath. Each of the RPC rounds reads the oldest
   // schedule word, then the schedule slides by one and the freshly expanded
   // word is appended, so words produced earlier in the cycle are visible to
   // the expansion of later rounds in the same cycle.
   always_comb begin : round_logic
      logic [31:0] ta, tb, tc, td, te;
      logic [31:0] temp;
      logic [31:0] wn;
      logic [6:0]  r;
      ta = a;
      tb = b;
      tc = c;
      td = d;
      te = e;
      temp = '0;
      wn = '0;
      r = '0;
      for (int i = 0; i < 16; i++) w_nx[i] = w[i];
      for (int j = 0; j < RPC; j++) begin
         r    = round_cnt + 7'(j);
         temp = {ta[26:0], ta[31:27]} + f_func(r, tb, tc, td) + te + k_func(r) + w_nx[0];
         te   = td;
         td   = tc;
         tc   = {tb[1:0], tb[31:2]};
         tb   = ta;
         ta   = temp;
         wn   = w_nx[13] ^ w_nx[8] ^ w_nx[2] ^ w_nx[0];
         for (int i = 0; i < 15; i++) w_nx[i] = w_nx[i + 1];
         w_nx[15] = {wn[30:0], wn[31]};
      end
      a_nx = ta;
      b_nx = tb;
      c_nx = tc;
      d_nx = td;
      e_nx = te;
   end

   // State register of the control FSM.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic: word 0 opens the block, word 15 starts compression,
   // the final round hands over to the one-cycle digest update.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept)
               state_next = LOAD;
         end
         LOAD: begin
            if (accept && word_cnt == 4'd15)
               state_next = COMP;
         end
         COMP: begin
            if (last_round)
               state_next = FIN;
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers. Accepted words slide into the schedule buffer from
   // the top, so after 16 accepts w[0] holds word 0. The working registers
   // and the chaining value are captured at the word-0 accept, which lets a
   // new block load while the previous digest is being consumed. dout keeps
   // the last digest after it is consumed because it doubles as the chaining
   // source for the next block.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt  <= '0;
         round_cnt <= '0;
         a         <= '0;
         b         <= '0;
         c         <= '0;
         d         <= '0;
         e         <= '0;
         cv        <= IV;
         dout      <= IV;
         dout_vld  <= 1'b0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         if (dout_vld && dout_rdy)
            dout_vld <= 1'b0;
         case (state)
            IDLE, LOAD: begin
               if (accept) begin
                  word_cnt <= word_cnt + 4'd1;
                  for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                  w[15] <= din;
                  if (state == IDLE) begin
                     {a, b, c, d, e} <= start_value;
                     cv              <= start_value;
                  end
               end
            end
            COMP: begin
               a <= a_nx;
               b <= b_nx;
               c <= c_nx;
               d <= d_nx;
               e <= e_nx;
               for (int i = 0; i < 16; i++) w[i] <= w_nx[i];
               if (last_round)
                  round_cnt <= '0;
               else
                  round_cnt <= round_cnt + 7'(RPC);
            end
            FIN: begin
               dout     <= {cv[159:128] + a, cv[127:96] + b, cv[95:64] + c,
                            cv[63:32] + d, cv[31:0] + e};
               dout_vld <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_core_unrolled.sv
// -----------------------------------------------------------------------------
// tb_sha1_core_unrolled
//
// Bench for sha1_core_unrolled. Four instances, one per legal RPC value, see
// identical word streams. A word is offered to all instances only when all of
// them are ready, so they stay in lockstep on the input side. Expected digests
// go into a per-instance queue when a block is issued; a monitor pops and
// compares each time an instance raises dout_vld, also checking latency from
// the word-15 accept and that dout holds steady while dout_vld is high.
// -----------------------------------------------------------------------------
module tb_sha1_core_unrolled;

   localparam int NDUT = 4;

   localparam logic [159:0] IV        = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                         32'h10325476, 32'hC3D2E1F0};
   localparam logic [159:0] DIG_ABC   = {32'ha9993e36, 32'h4706816a, 32'hba3e2571,
                                         32'h7850c26c, 32'h9cd0d89d};
   localparam logic [159:0] DIG_EMPTY = {32'hda39a3ee, 32'h5e6b4b0d, 32'h3255bfef,
                                         32'h95601890, 32'hafd80709};
   localparam logic [159:0] DIG_TWO   = {32'h84983e44, 32'h1c3bd26e, 32'hbaae4aa1,
                                         32'hf95129e5, 32'he54670f1};

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_TWO_1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};

   logic                 clk = 1'b0;
   logic [NDUT-1:0]      rst_v;
   logic                 din_vld;
   logic [31:0]          din;
   logic                 chain;
   logic                 dout_rdy;
   logic [NDUT-1:0]      din_vld_v;
   logic [NDUT-1:0]      din_rdy_v;
   logic [NDUT-1:0]      busy_v;
   logic [NDUT-1:0]      dout_vld_v;
   logic [159:0]         dout_a [NDUT];
   logic                 all_rdy;

   int                   checks = 0;
   int                   failures = 0;
   int                   cyc = 0;
   int                   t15 = 0;

   // {care, digest}; care=0 means only latency is checked for that output
   logic [160:0]         exp_q [NDUT][$];
   logic [159:0]         held [NDUT];
   logic [NDUT-1:0]      prev_vld = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rpc_of(input int g);
      case (g)
         0: return 1;
         1: return 2;
         2: return 4;
         default: return 5;
      endcase
   endfunction

   assign all_rdy = &din_rdy_v;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int P = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5;
      assign din_vld_v[g] = din_vld & all_rdy;
      sha1_core_unrolled #(.RPC(P)) u_dut (
         .clk      (clk),
         .rst      (rst_v[g]),
         .din_vld  (din_vld_v[g]),
         .din_rdy  (din_rdy_v[g]),
         .din      (din),
         .chain    (chain),
         .busy     (busy_v[g]),
         .dout     (dout_a[g]),
         .dout_vld (dout_vld_v[g]),
         .dout_rdy (dout_rdy)
      );
   end

   // One comparison: counts it, reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [159:0] act,
                              input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_all(input logic care, input logic [159:0] dig);
      for (int g = 0; g < NDUT; g++) exp_q[g].push_back({care, dig});
   endtask

   // Drives one 16-word block. With gaps set, random idle cycles with junk
   // on din/chain are inserted. chain carries the inverse of chn on words
   // 1-15 so that a core sampling it there would be caught.
   task automatic applyStimulus(input logic [511:0] blk, input logic chn, input bit gaps);
      int n;
      int waited;
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
               @(negedge clk);
               din_vld = 1'b0;
               din     = $urandom;
               chain   = 1'($urandom);
            end
         end
         @(negedge clk);
         din_vld = 1'b1;
         din     = blk[511 - 32*i -: 32];
         chain   = (i == 0) ? chn : ~chn;
         waited  = 0;
         while (!all_rdy && waited < 2000) begin
            @(negedge clk);
            waited++;
         end
         if (!all_rdy) begin
            checkOutput("din_rdy_timeout", 160'(all_rdy), 160'(1));
            din_vld = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (i == 0)
            checkOutput("busy_after_word0", 160'(busy_v), 160'({NDUT{1'b1}}));
         if (i == 15) begin
            t15     = cyc;
            din_vld = 1'b0;
         end
      end
   endtask

   task automatic wait_drain();
      int  n;
      bit  pending;
      n = 0;
      pending = 1'b1;
      while (pending && n < 3000) begin
         @(negedge clk);
         n++;
         pending = (|dout_vld_v) || (|busy_v);
         for (int g = 0; g < NDUT; g++)
            if (exp_q[g].size() != 0) pending = 1'b1;
      end
      if (pending)
         checkOutput("drain_timeout", 160'(pending), 160'(0));
   endtask

   // Scoreboard monitor: a rising dout_vld pops the expected digest; while
   // dout_vld stays high the value must not move.
   always @(negedge clk) begin
      logic [160:0] e;
      for (int g = 0; g < NDUT; g++) begin
         if (dout_vld_v[g] && !prev_vld[g]) begin
            if (exp_q[g].size() == 0) begin
               checkOutput($sformatf("unexpected_dout_vld_rpc%0d", rpc_of(g)),
                           160'(dout_vld_v[g]), 160'(0));
            end else begin
               e = exp_q[g].pop_front();
               if (e[160])
                  checkOutput($sformatf("digest_rpc%0d", rpc_of(g)), dout_a[g], e[159:0]);
               checkOutput($sformatf("latency_rpc%0d", rpc_of(g)),
                           160'(cyc - t15 + 1), 160'(80 / rpc_of(g) + 2));
            end
            checkOutput($sformatf("busy_at_dout_vld_rpc%0d", rpc_of(g)),
                        160'(busy_v[g]), 160'(0));
            held[g] = dout_a[g];
         end else if (dout_vld_v[g]) begin
            checkOutput($sformatf("dout_stable_rpc%0d", rpc_of(g)), dout_a[g], held[g]);
         end
         prev_vld[g] = dout_vld_v[g];
      end
   end

   initial begin
      rst_v    = '1;
      din_vld  = 1'b0;
      din      = '0;
      chain    = 1'b0;
      dout_rdy = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      for (int g = 0; g < NDUT; g++)
         checkOutput($sformatf("reset_dout_rpc%0d", rpc_of(g)), dout_a[g], IV);
      checkOutput("reset_din_rdy", 160'(din_rdy_v), 160'({NDUT{1'b1}}));
      checkOutput("reset_busy", 160'(busy_v), 160'(0));
      checkOutput("reset_dout_vld", 160'(dout_vld_v), 160'(0));
      rst_v = '0;

      $display("[TB] single block abc");
      expect_all(1'b1, DIG_ABC);
      applyStimulus(BLK_ABC, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("din_rdy_in_comp", 160'(din_rdy_v), 160'(0));
      wait_drain();

      $display("[TB] empty message");
      expect_all(1'b1, DIG_EMPTY);
      applyStimulus(BLK_EMPTY, 1'b0, 1'b0);
      wait_drain();

      $display("[TB] two-block message then unchained block");
      expect_all(1'b0, '0);
      applyStimulus(BLK_TWO_1, 1'b0, 1'b0);
      expect_all(1'b1, DIG_TWO);
      applyStimulus(BLK_TWO_2, 1'b1, 1'b0);
      expect_all(1'b1, DIG_ABC);
      applyStimulus(BLK_ABC, 1'b0, 1'b0);
      wait_drain();

      $display("[TB] stalls and backpressure");
      @(negedge clk);
      dout_rdy = 1'b0;
      expect_all(1'b1, DIG_ABC);
      applyStimulus(BLK_ABC, 1'b0, 1'b1);
      begin
         int n;
         n = 0;
         while (dout_vld_v != '1 && n < 2000) begin
            @(negedge clk);
            n++;
         end
         checkOutput("all_dout_vld", 160'(dout_vld_v), 160'({NDUT{1'b1}}));
      end
      repeat (20) begin
         @(negedge clk);
         checkOutput("din_rdy_backpressure", 160'(din_rdy_v), 160'(0));
      end
      dout_rdy = 1'b1;
      #1;
      checkOutput("din_rdy_on_dout_rdy", 160'(din_rdy_v), 160'({NDUT{1'b1}}));
      wait_drain();

      $display("[TB] reset at round 40");
      applyStimulus(BLK_EMPTY, 1'b1, 1'b0);
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         for (int g = 0; g < NDUT; g++)
            rst_v[g] = (k == 40 / rpc_of(g) + 1);
      end
      @(negedge clk);
      rst_v = '0;
      for (int g = 0; g < NDUT; g++)
         checkOutput($sformatf("post_reset_dout_rpc%0d", rpc_of(g)), dout_a[g], IV);
      checkOutput("post_reset_dout_vld", 160'(dout_vld_v), 160'(0));
      checkOutput("post_reset_din_rdy", 160'(din_rdy_v), 160'({NDUT{1'b1}}));
      expect_all(1'b1, DIG_ABC);
      applyStimulus(BLK_ABC, 1'b1, 1'b0);
      wait_drain();

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
